// File: rtl/seg_scan_driver.sv
// seg_scan_driver: scan index + segment pattern generator for an 8-digit
// multiplexed 7-segment display. The displayed digits come from a double
// buffer. The active copy is only replaced at the frame boundary, so a frame
// never shows a mix of old and new digits. The first BLANK_CYCLES cycles of
// every slot are dark to hide ghosting while the com lines switch.
module seg_scan_driver #(
    parameter int CLK_DIV      = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scan_en,
    input  logic        load,
    input  logic [31:0] digits_in,
    input  logic [7:0]  dp_in,
    input  logic        lz_en,
    output logic [2:0]  count,
    output logic [7:0]  seg,
    output logic        blank,
    output logic        frame_done
);

    localparam int             DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW:0]    BLANK_W  = (DW+1)'(BLANK_CYCLES);

    logic [DW-1:0] div_cnt;
    logic [31:0]   shadow_dig, active_dig;
    logic [7:0]    shadow_dp,  active_dp;
    logic          pending;

    // next-state signals; outputs are registered from these so that count,
    // seg, blank and frame_done all move on the same edge
    logic          slot_end, wrap;
    logic [DW-1:0] div_nxt;
    logic [2:0]    cnt_nxt;
    logic [31:0]   act_dig_nxt;
    logic [7:0]    act_dp_nxt;
    logic [3:0]    nib;
    logic          dp_bit;
    logic [7:0]    lead_zero;
    logic          suppress;
    logic          blank_nxt;
    logic [7:0]    seg_nxt;

    // hex to {a,b,c,d,e,f,g}
    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b1111110;
            4'h1: hex7 = 7'b0110000;
            4'h2: hex7 = 7'b1101101;
            4'h3: hex7 = 7'b1111001;
            4'h4: hex7 = 7'b0110011;
            4'h5: hex7 = 7'b1011011;
            4'h6: hex7 = 7'b1011111;
            4'h7: hex7 = 7'b1110000;
            4'h8: hex7 = 7'b1111111;
            4'h9: hex7 = 7'b1111011;
            4'hA: hex7 = 7'b1110111;
            4'hB: hex7 = 7'b0011111;
            4'hC: hex7 = 7'b1001110;
            4'hD: hex7 = 7'b0111101;
            4'hE: hex7 = 7'b1001111;
            default: hex7 = 7'b1000111;
        endcase
    endfunction

    // slot timing, buffer swap selection and segment decode for the next cycle
    always_comb begin
        slot_end = (div_cnt == DIV_LAST);
        wrap     = scan_en && slot_end && (count == 3'd7);
        div_nxt  = slot_end ? '0 : div_cnt + 1'b1;
        cnt_nxt  = slot_end ? count + 3'd1 : count;

        // a load landing on the boundary edge bypasses the shadow copy
        act_dig_nxt = active_dig;
        act_dp_nxt  = active_dp;
        if (wrap && load) begin
            act_dig_nxt = digits_in;
            act_dp_nxt  = dp_in;
        end else if (wrap && pending) begin
            act_dig_nxt = shadow_dig;
            act_dp_nxt  = shadow_dp;
        end

        // count 0 is the leftmost digit, held in the top nibble; 7-c == ~c
        nib    = act_dig_nxt[{~cnt_nxt, 2'b00} +: 4];
        dp_bit = act_dp_nxt[~cnt_nxt];

        // lead_zero[i]: digit i and everything to its left are zero
        lead_zero = '0;
        for (int i = 0; i < 8; i++) begin
            lead_zero[i] = (act_dig_nxt[31-4*i -: 4] == 4'h0) &&
                           ((i == 0) ? 1'b1 : lead_zero[i-1]);
        end
        suppress = lz_en && (cnt_nxt != 3'd7) && lead_zero[cnt_nxt];

        blank_nxt = ({1'b0, div_nxt} < BLANK_W);
        seg_nxt   = (blank_nxt || suppress) ? 8'h00 : {hex7(nib), dp_bit};
    end

    // scan state, double buffer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            count      <= 3'd0;
            seg        <= 8'h00;
            blank      <= 1'b1;
            frame_done <= 1'b0;
            shadow_dig <= '0;
            shadow_dp  <= '0;
            active_dig <= '0;
            active_dp  <= '0;
            pending    <= 1'b0;
        end else begin
            if (load) begin
                shadow_dig <= digits_in;
                shadow_dp  <= dp_in;
                pending    <= 1'b1;
            end
            if (!scan_en) begin
                // parked at the start of the held slot, so re-enable
                // begins with a full blanking interval
                div_cnt    <= '0;
                seg        <= 8'h00;
                blank      <= 1'b1;
                frame_done <= 1'b0;
            end else begin
                div_cnt    <= div_nxt;
                count      <= cnt_nxt;
                seg        <= seg_nxt;
                blank      <= blank_nxt;
                frame_done <= wrap;
                active_dig <= act_dig_nxt;
                active_dp  <= act_dp_nxt;
                if (wrap) pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver. The driver applies stimulus once
// per clock and pushes the model's expected outputs into a queue. A monitor
// on the falling edge pops and compares. The model tracks a single
// frame-time position t in 0..8*CD-1 and the two digit buffers.
module tb_seg_scan_driver;

    localparam int CD = 4;
    localparam int BL = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scan_en = 1'b0;
    logic        load = 1'b0;
    logic [31:0] digits_in = '0;
    logic [7:0]  dp_in = '0;
    logic        lz_en = 1'b0;
    logic [2:0]  count;
    logic [7:0]  seg;
    logic        blank;
    logic        frame_done;

    seg_scan_driver #(.CLK_DIV(CD), .BLANK_CYCLES(BL)) dut (
        .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .load(load),
        .digits_in(digits_in), .dp_in(dp_in), .lz_en(lz_en),
        .count(count), .seg(seg), .blank(blank), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] cnt;
        logic [7:0] sg;
        logic       bl;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   mon_on = 1'b0;

    localparam logic [6:0] SEGTAB [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    // model state
    int          t;
    logic [31:0] m_act, m_shd;
    logic [7:0]  m_actdp, m_shddp;
    bit          m_pend;

    function automatic int digit_of(input logic [31:0] v, input int slot);
        return int'((v >> (4 * (7 - slot))) & 32'hF);
    endfunction

    task automatic model_reset();
        t = 0; m_act = '0; m_shd = '0; m_actdp = '0; m_shddp = '0; m_pend = 0;
    endtask

    // one clock: drive inputs, advance the model across the edge, queue expectation
    task automatic step(input bit se, input bit ld, input logic [31:0] d,
                        input logic [7:0] p, input bit lz);
        exp_t e;
        int   slot, pos, nb;
        bit   wrap, supp;
        scan_en = se; load = ld; digits_in = d; dp_in = p; lz_en = lz;
        @(posedge clk);
        if (ld) begin m_shd = d; m_shddp = p; end
        if (!se) begin
            t = t - (t % CD);
            if (ld) m_pend = 1;
            e.cnt = 3'(t / CD); e.sg = 8'h00; e.bl = 1'b1; e.fd = 1'b0;
        end else begin
            t    = (t + 1) % (8 * CD);
            wrap = (t == 0);
            if (wrap) begin
                if (ld) begin m_act = d; m_actdp = p; end
                else if (m_pend) begin m_act = m_shd; m_actdp = m_shddp; end
                m_pend = 0;
            end else if (ld) m_pend = 1;
            slot = t / CD;
            pos  = t % CD;
            nb   = digit_of(m_act, slot);
            supp = lz && slot != 7;
            for (int j = 0; j <= slot; j++)
                if (digit_of(m_act, j) != 0) supp = 0;
            e.cnt = 3'(slot);
            e.bl  = (pos < BL);
            e.fd  = wrap;
            e.sg  = (e.bl || supp) ? 8'h00 : {SEGTAB[nb], m_actdp[7 - slot]};
        end
        q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n, input bit lz);
        for (int i = 0; i < n; i++) step(1, 0, $urandom, 8'($urandom), lz);
    endtask

    task automatic chk_rst(input string name);
        checks++;
        if (count !== 3'd0 || seg !== 8'h00 || blank !== 1'b1 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL %s got cnt=%0d seg=%b blank=%b fd=%b exp cnt=0 seg=00000000 blank=1 fd=0",
                     name, count, seg, blank, frame_done);
        end
    endtask

    // monitor: compare DUT outputs against queued expectations each cycle
    always @(negedge clk) begin
        if (mon_on && q.size() > 0) begin
            exp_t e, g;
            e = q.pop_front();
            g = '{count, seg, blank, frame_done};
            cyc++;
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL scb cyc=%0d got cnt=%0d seg=%b blank=%b fd=%b exp cnt=%0d seg=%b blank=%b fd=%b",
                         cyc, g.cnt, g.sg, g.bl, g.fd, e.cnt, e.sg, e.bl, e.fd);
            end
        end
    end

    initial begin
        bit lz;
        // reset held
        repeat (3) @(negedge clk);
        chk_rst("reset_hold");
        rst_n = 1'b1;
        model_reset();
        mon_on = 1'b1;

        // basic decode 0x01234567
        step(1, 1, 32'h01234567, 8'h00, 0);
        idle(80, 0);

        // leading-zero suppression
        step(1, 1, 32'h00000000, 8'h00, 1);
        idle(40, 1);
        step(1, 1, 32'h00100200, 8'h00, 1);
        idle(40, 1);

        // tear-free update issued during count 3
        while (t / CD != 3) step(1, 0, $urandom, 8'($urandom), 0);
        step(1, 1, 32'h88888888, 8'hFF, 0);
        idle(40, 0);

        // load coincident with the 7->0 wrap
        while (t != 8 * CD - 1) step(1, 0, $urandom, 8'($urandom), 0);
        step(1, 1, 32'hAAAAAAAA, 8'h00, 0);
        idle(10, 0);

        // scan_en drop mid-slot at count 5, including a load while dark
        while (t != 5 * CD + 1) step(1, 0, $urandom, 8'($urandom), 0);
        for (int i = 0; i < 10; i++)
            step(0, i == 4, 32'h00000F00, 8'h01, 1);
        idle(50, 1);

        // asynchronous reset mid-slot, away from any clock edge
        while (t / CD != 3 || t % CD != 2) step(1, 0, $urandom, 8'($urandom), 0);
        @(negedge clk);
        #1;
        mon_on = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_rst("reset_async");
        @(negedge clk);
        chk_rst("reset_async_hold");
        q.delete();
        rst_n = 1'b1;
        model_reset();
        mon_on = 1'b1;

        // randomized traffic
        lz = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] d;
            for (int k = 0; k < 8; k++)
                d[4*k +: 4] = ($urandom_range(1, 0) == 0) ? 4'h0 : 4'($urandom);
            if ($urandom_range(99, 0) < 2) lz = ~lz;
            step($urandom_range(9, 0) != 0, $urandom_range(11, 0) == 0, d, 8'($urandom), lz);
        end

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got %0d left exp 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
